// File: rtl/ls_axi_bridge_pkg.sv
// ls_axi_pkg: shared types and AXI field constants for the load/store AXI bridge.
//   state_e        bridge FSM states
//   AXI_*          fixed AXI field encodings for single-word transfers
//   word_addr()    word-aligns a byte address
package ls_axi_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_ADDR = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_WR      = 3'd3,
    ST_WR_RESP = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

  localparam logic [2:0] AXI_SIZE_WORD  = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [3:0] AXI_CACHE_WBRA = 4'b1111;
  localparam logic [3:0] AXI_CACHE_DEV  = 4'b0000;

  // Force the two byte-offset bits to zero.
  function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] a);
    return a & ~ADDR_W'(3);
  endfunction

endpackage

// File: rtl/ls_axi_bridge_if.sv
// Interfaces for the load/store bridge.
//   ls_core_if : core data port (master = core, slave = bridge)
//                ren/wen/wsel/addr/wdata/cached/flush -> ; <- rdata/rvalid/bvalid
//   ls_axi_if  : single-beat AXI4 port (master = bridge, slave = interconnect)
//                AR, R, AW, W, B channels
interface ls_core_if;
  import ls_axi_pkg::*;

  logic              ren;
  logic              wen;
  logic [STRB_W-1:0] wsel;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              cached;
  logic              flush;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;
  logic              bvalid;

  modport master (output ren, wen, wsel, addr, wdata, cached, flush,
                  input  rdata, rvalid, bvalid);
  modport slave  (input  ren, wen, wsel, addr, wdata, cached, flush,
                  output rdata, rvalid, bvalid);
endinterface

interface ls_axi_if #(parameter int unsigned ID_W = 4);
  import ls_axi_pkg::*;

  logic [ID_W-1:0]   arid;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic [3:0]        arcache;
  logic              arvalid;
  logic              arready;

  logic [ID_W-1:0]   rid;
  logic [DATA_W-1:0] axi_rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              axi_rvalid;
  logic              rready;

  logic [ID_W-1:0]   awid;
  logic [ADDR_W-1:0] awaddr;
  logic [7:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;
  logic [3:0]        awcache;
  logic              awvalid;
  logic              awready;

  logic [DATA_W-1:0] axi_wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wlast;
  logic              wvalid;
  logic              wready;

  logic [ID_W-1:0]   bid;
  logic [1:0]        bresp;
  logic              axi_bvalid;
  logic              bready;

  modport master (output arid, araddr, arlen, arsize, arburst, arcache, arvalid,
                  input  arready,
                  input  rid, axi_rdata, rresp, rlast, axi_rvalid, output rready,
                  output awid, awaddr, awlen, awsize, awburst, awcache, awvalid,
                  input  awready,
                  output axi_wdata, wstrb, wlast, wvalid, input wready,
                  input  bid, bresp, axi_bvalid, output bready);
  modport slave  (input  arid, araddr, arlen, arsize, arburst, arcache, arvalid,
                  output arready,
                  output rid, axi_rdata, rresp, rlast, axi_rvalid, input rready,
                  input  awid, awaddr, awlen, awsize, awburst, awcache, awvalid,
                  output awready,
                  input  axi_wdata, wstrb, wlast, wvalid, output wready,
                  output bid, bresp, axi_bvalid, input bready);
endinterface

// File: rtl/ls_axi_bridge.sv
// ls_axi_bridge: runs each core load/store as one single-beat AXI4 transaction.
//   clock, reset : sole clock, synchronous active-high reset
//   core         : ls_core_if.slave, request in, rdata/rvalid/bvalid out
//   axi          : ls_axi_if.master, AR/R/AW/W/B
// A flush marks the in-flight request killed; the AXI side still finishes,
// only the core completion pulse is dropped.
module ls_axi_bridge
  import ls_axi_pkg::*;
#(
  parameter int unsigned ID_W = 4
) (
  input  logic      clock,
  input  logic      reset,
  ls_core_if.slave  core,
  ls_axi_if.master  axi
);

  state_e            r_state,    w_state_n;
  logic              r_is_write, w_is_write_n;
  logic              r_killed,   w_killed_n;
  logic              r_aw_done,  w_aw_done_n;
  logic              r_w_done,   w_w_done_n;
  logic              r_active,   w_active_n;
  logic [ADDR_W-1:0] r_addr,     w_addr_n;
  logic [DATA_W-1:0] r_wdata,    w_wdata_n;
  logic [STRB_W-1:0] r_wsel,     w_wsel_n;
  logic              r_cached,   w_cached_n;
  logic              r_arvalid,  w_arvalid_n;
  logic              r_awvalid,  w_awvalid_n;
  logic              r_wvalid,   w_wvalid_n;
  logic              r_rready,   w_rready_n;
  logic              r_bready,   w_bready_n;
  logic [DATA_W-1:0] r_rdata,    w_rdata_n;
  logic              r_rd_ok,    w_rd_ok_n;
  logic              r_wr_ok,    w_wr_ok_n;
  logic              w_aw_hs;
  logic              w_w_hs;

  // State and request registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_is_write <= 1'b0;
      r_killed   <= 1'b0;
      r_aw_done  <= 1'b0;
      r_w_done   <= 1'b0;
      r_active   <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wsel     <= '0;
      r_cached   <= 1'b0;
      r_arvalid  <= 1'b0;
      r_awvalid  <= 1'b0;
      r_wvalid   <= 1'b0;
      r_rready   <= 1'b0;
      r_bready   <= 1'b0;
      r_rdata    <= '0;
      r_rd_ok    <= 1'b0;
      r_wr_ok    <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_is_write <= w_is_write_n;
      r_killed   <= w_killed_n;
      r_aw_done  <= w_aw_done_n;
      r_w_done   <= w_w_done_n;
      r_active   <= w_active_n;
      r_addr     <= w_addr_n;
      r_wdata    <= w_wdata_n;
      r_wsel     <= w_wsel_n;
      r_cached   <= w_cached_n;
      r_arvalid  <= w_arvalid_n;
      r_awvalid  <= w_awvalid_n;
      r_wvalid   <= w_wvalid_n;
      r_rready   <= w_rready_n;
      r_bready   <= w_bready_n;
      r_rdata    <= w_rdata_n;
      r_rd_ok    <= w_rd_ok_n;
      r_wr_ok    <= w_wr_ok_n;
    end
  end

  // Next-state and next-register logic; every channel control is registered.
  always_comb begin
    w_state_n    = r_state;
    w_is_write_n = r_is_write;
    w_killed_n   = r_killed;
    w_aw_done_n  = r_aw_done;
    w_w_done_n   = r_w_done;
    w_active_n   = r_active;
    w_addr_n     = r_addr;
    w_wdata_n    = r_wdata;
    w_wsel_n     = r_wsel;
    w_cached_n   = r_cached;
    w_arvalid_n  = r_arvalid;
    w_awvalid_n  = r_awvalid;
    w_wvalid_n   = r_wvalid;
    w_rready_n   = r_rready;
    w_bready_n   = r_bready;
    w_rdata_n    = r_rdata;
    w_rd_ok_n    = 1'b0;
    w_wr_ok_n    = 1'b0;
    w_aw_hs      = r_awvalid & axi.awready;
    w_w_hs       = r_wvalid & axi.wready;

    if ((r_state != ST_IDLE) && core.flush) begin
      w_killed_n = 1'b1;
    end

    unique case (r_state)
      ST_IDLE: begin
        if (!core.flush && (core.wen || core.ren)) begin
          w_is_write_n = core.wen;
          w_killed_n   = 1'b0;
          w_active_n   = 1'b1;
          w_addr_n     = word_addr(core.addr);
          w_wdata_n    = core.wdata;
          w_wsel_n     = core.wsel;
          w_cached_n   = core.cached;
          if (core.wen) begin
            w_state_n   = ST_WR;
            w_awvalid_n = 1'b1;
            w_wvalid_n  = 1'b1;
            w_aw_done_n = 1'b0;
            w_w_done_n  = 1'b0;
          end else begin
            w_state_n   = ST_RD_ADDR;
            w_arvalid_n = 1'b1;
          end
        end
      end
      ST_RD_ADDR: begin
        if (axi.arready) begin
          w_arvalid_n = 1'b0;
          w_rready_n  = 1'b1;
          w_state_n   = ST_RD_DATA;
        end
      end
      ST_RD_DATA: begin
        if (axi.axi_rvalid && axi.rlast) begin
          w_rdata_n  = axi.axi_rdata;
          w_rready_n = 1'b0;
          w_rd_ok_n  = !r_is_write && !w_killed_n;
          w_state_n  = ST_DONE;
        end
      end
      ST_WR: begin
        // AW and W complete independently; sticky flags remember each.
        if (w_aw_hs) begin
          w_awvalid_n = 1'b0;
          w_aw_done_n = 1'b1;
        end
        if (w_w_hs) begin
          w_wvalid_n = 1'b0;
          w_w_done_n = 1'b1;
        end
        if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) begin
          w_aw_done_n = 1'b0;
          w_w_done_n  = 1'b0;
          w_bready_n  = 1'b1;
          w_state_n   = ST_WR_RESP;
        end
      end
      ST_WR_RESP: begin
        if (axi.axi_bvalid) begin
          w_bready_n = 1'b0;
          w_wr_ok_n  = r_is_write && !w_killed_n;
          w_state_n  = ST_DONE;
        end
      end
      ST_DONE: begin
        // The core still holds its request here; it is deliberately not sampled.
        w_state_n = ST_IDLE;
      end
      default: w_state_n = ST_IDLE;
    endcase
  end

  // Core side; a flush raised during DONE still suppresses the pulse.
  assign core.rdata  = r_rdata;
  assign core.rvalid = r_rd_ok & ~core.flush;
  assign core.bvalid = r_wr_ok & ~core.flush;

  // AXI request fields; fixed encodings stay 0 until the first request after reset.
  assign axi.arid      = ID_W'(0);
  assign axi.araddr    = r_addr;
  assign axi.arlen     = 8'd0;
  assign axi.arsize    = r_active ? AXI_SIZE_WORD : 3'b000;
  assign axi.arburst   = r_active ? AXI_BURST_INCR : 2'b00;
  assign axi.arcache   = r_cached ? AXI_CACHE_WBRA : AXI_CACHE_DEV;
  assign axi.arvalid   = r_arvalid;
  assign axi.rready    = r_rready;

  assign axi.awid      = ID_W'(0);
  assign axi.awaddr    = r_addr;
  assign axi.awlen     = 8'd0;
  assign axi.awsize    = r_active ? AXI_SIZE_WORD : 3'b000;
  assign axi.awburst   = r_active ? AXI_BURST_INCR : 2'b00;
  assign axi.awcache   = r_cached ? AXI_CACHE_WBRA : AXI_CACHE_DEV;
  assign axi.awvalid   = r_awvalid;

  assign axi.axi_wdata = r_wdata;
  assign axi.wstrb     = r_wsel;
  assign axi.wlast     = r_active;
  assign axi.wvalid    = r_wvalid;

  assign axi.bready    = r_bready;

  // Response IDs and codes carry no information for a single-outstanding master.
  logic w_unused_ok;
  assign w_unused_ok = ^{axi.rid, axi.rresp, axi.bid, axi.bresp};

endmodule

// File: tb/tb_ls_axi_bridge.sv
// Self-checking bench for ls_axi_bridge: the bench plays both the core and an
// AXI slave with programmable stalls, and predicts addresses, cache codes,
// handshake counts and completion latency from the transfer parameters.
module tb_ls_axi_bridge;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  logic [31:0] model_rdata = '0;

  always #5 clk = ~clk;

  ls_core_if          core_if ();
  ls_axi_if #(.ID_W(4)) axi_if ();

  ls_axi_bridge #(.ID_W(4)) dut (
    .clock (clk),
    .reset (rst),
    .core  (core_if),
    .axi   (axi_if)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic any_out();
    return |{core_if.rdata, core_if.rvalid, core_if.bvalid,
             axi_if.arid, axi_if.araddr, axi_if.arlen, axi_if.arsize, axi_if.arburst,
             axi_if.arcache, axi_if.arvalid, axi_if.rready,
             axi_if.awid, axi_if.awaddr, axi_if.awlen, axi_if.awsize, axi_if.awburst,
             axi_if.awcache, axi_if.awvalid, axi_if.axi_wdata, axi_if.wstrb,
             axi_if.wlast, axi_if.wvalid, axi_if.bready};
  endfunction

  // One load; fl_at = cycle after sampling at which flush is raised (-1: none).
  task automatic run_load(input logic [31:0] a, input logic c, input int ar_st,
                          input int r_st, input int fl_at, input bit chain);
    logic [31:0] d, got_addr;
    logic [3:0]  got_cache;
    logic [12:0] got_fix;
    int ar_cnt, r_cnt, ar_hs, pulses, bpulses, pulse_n, rgap, ar_extra, exp_lat;
    bit ar_done, r_done, killed, seen, fin;
    ar_cnt = 0; r_cnt = 0; ar_hs = 0; pulses = 0; bpulses = 0; pulse_n = -1;
    rgap = 0; ar_extra = 0; ar_done = 0; r_done = 0; killed = 0; seen = 0; fin = 0;
    got_addr = '0; got_cache = '0; got_fix = '0;
    d = $urandom;
    exp_lat = 3 + ar_st + r_st;
    core_if.addr = a; core_if.cached = c; core_if.wdata = $urandom;
    core_if.wsel = 4'($urandom); core_if.wen = 1'b0; core_if.ren = 1'b1; core_if.flush = 1'b0;
    for (int n = 1; n <= 80 && !fin; n++) begin
      step();
      axi_if.arready = 1'b0; axi_if.axi_rvalid = 1'b0; axi_if.rlast = 1'b0;
      core_if.flush = (n == fl_at);
      if (n == fl_at) begin killed = 1; core_if.ren = 1'b0; end
      if (r_done) begin fin = 1; if (!chain) core_if.ren = 1'b0; end
      #1;
      if (core_if.rvalid) begin
        pulses++; pulse_n = n;
        checks++;
        if (core_if.rdata !== d) begin
          errors++; $display("FAIL load_rdata: got %h want %h", core_if.rdata, d);
        end
      end
      if (core_if.bvalid) bpulses++;
      if (ar_done && !r_done && !axi_if.rready) rgap++;
      if (ar_done && axi_if.arvalid) ar_extra++;
      if (axi_if.arvalid && !ar_done) begin
        if (!seen) begin
          seen = 1; got_addr = axi_if.araddr; got_cache = axi_if.arcache;
          got_fix = {axi_if.arlen, axi_if.arsize, axi_if.arburst};
        end
        ar_cnt++;
        if (ar_cnt > ar_st) begin axi_if.arready = 1'b1; ar_hs++; ar_done = 1; end
      end else if (ar_done && !r_done && axi_if.rready) begin
        r_cnt++;
        if (r_cnt > r_st) begin
          axi_if.axi_rvalid = 1'b1; axi_if.rlast = 1'b1; axi_if.axi_rdata = d;
          axi_if.rid = 4'($urandom); axi_if.rresp = 2'($urandom);
          r_done = 1; model_rdata = d;
        end
      end
    end
    checks++;
    if (!fin) begin
      errors++; $display("FAIL load_timeout: got done=%0d want 1", fin);
      core_if.ren = 1'b0;
    end
    checks++;
    if (ar_hs != 1 || ar_extra != 0) begin
      errors++; $display("FAIL load_ar_count: got hs=%0d extra=%0d want 1/0", ar_hs, ar_extra);
    end
    checks++;
    if (got_addr !== (a & 32'hFFFF_FFFC)) begin
      errors++; $display("FAIL load_araddr: got %h want %h", got_addr, a & 32'hFFFF_FFFC);
    end
    checks++;
    if (got_cache !== (c ? 4'hF : 4'h0) || got_fix !== {8'd0, 3'b010, 2'b01}) begin
      errors++; $display("FAIL load_fields: got cache=%h fix=%h want %h %h",
                         got_cache, got_fix, c ? 4'hF : 4'h0, {8'd0, 3'b010, 2'b01});
    end
    checks++;
    if (pulses != (killed ? 0 : 1) || bpulses != 0) begin
      errors++; $display("FAIL load_pulses: got r=%0d b=%0d want %0d 0", pulses, bpulses, killed ? 0 : 1);
    end
    checks++;
    if (rgap != 0) begin
      errors++; $display("FAIL load_rready_held: got gaps=%0d want 0", rgap);
    end
    if (!killed) begin
      checks++;
      if (pulse_n != exp_lat) begin
        errors++; $display("FAIL load_latency: got %0d want %0d", pulse_n, exp_lat);
      end
    end
    step();
    core_if.flush = 1'b0;
    checks++;
    if (axi_if.arvalid !== 1'b0 || axi_if.awvalid !== 1'b0) begin
      errors++; $display("FAIL load_no_reissue: got arvalid=%b want 0", axi_if.arvalid);
    end
  endtask

  task automatic run_store(input logic [31:0] a, input logic c, input logic [3:0] ws,
                           input logic [31:0] wd, input int aw_st, input int w_st,
                           input int b_st, input int fl_at);
    logic [31:0] got_addr, got_wdata;
    logic [3:0]  got_cache, got_strb;
    logic [12:0] got_fix;
    logic        got_last;
    int aw_cnt, w_cnt, b_cnt, pulses, rpulses, pulse_n, early, bgap, aw_extra, w_extra, exp_lat;
    bit aw_done, w_done, b_done, both, killed, seen_aw, seen_w, fin;
    aw_cnt = 0; w_cnt = 0; b_cnt = 0; pulses = 0; rpulses = 0; pulse_n = -1;
    early = 0; bgap = 0; aw_extra = 0; w_extra = 0;
    aw_done = 0; w_done = 0; b_done = 0; killed = 0; seen_aw = 0; seen_w = 0; fin = 0;
    got_addr = '0; got_wdata = '0; got_cache = '0; got_strb = '0; got_fix = '0; got_last = 0;
    exp_lat = 3 + ((aw_st > w_st) ? aw_st : w_st) + b_st;
    core_if.addr = a; core_if.cached = c; core_if.wsel = ws; core_if.wdata = wd;
    core_if.ren = 1'b0; core_if.wen = 1'b1; core_if.flush = 1'b0;
    for (int n = 1; n <= 80 && !fin; n++) begin
      step();
      axi_if.awready = 1'b0; axi_if.wready = 1'b0; axi_if.axi_bvalid = 1'b0;
      core_if.flush = (n == fl_at);
      if (n == fl_at) begin killed = 1; core_if.wen = 1'b0; end
      if (b_done) begin fin = 1; core_if.wen = 1'b0; end
      #1;
      if (core_if.bvalid) begin pulses++; pulse_n = n; end
      if (core_if.rvalid) rpulses++;
      both = aw_done && w_done;
      if (axi_if.bready && !both) early++;
      if (both && !b_done && !axi_if.bready) bgap++;
      if (aw_done && axi_if.awvalid) aw_extra++;
      if (w_done && axi_if.wvalid) w_extra++;
      if (axi_if.awvalid && !aw_done) begin
        if (!seen_aw) begin
          seen_aw = 1; got_addr = axi_if.awaddr; got_cache = axi_if.awcache;
          got_fix = {axi_if.awlen, axi_if.awsize, axi_if.awburst};
        end
        aw_cnt++;
        if (aw_cnt > aw_st) begin axi_if.awready = 1'b1; aw_done = 1; end
      end
      if (axi_if.wvalid && !w_done) begin
        if (!seen_w) begin
          seen_w = 1; got_wdata = axi_if.axi_wdata; got_strb = axi_if.wstrb; got_last = axi_if.wlast;
        end
        w_cnt++;
        if (w_cnt > w_st) begin axi_if.wready = 1'b1; w_done = 1; end
      end
      if (both && !b_done && axi_if.bready) begin
        b_cnt++;
        if (b_cnt > b_st) begin
          axi_if.axi_bvalid = 1'b1; axi_if.bid = 4'($urandom); axi_if.bresp = 2'($urandom);
          b_done = 1;
        end
      end
    end
    checks++;
    if (!fin) begin
      errors++; $display("FAIL store_timeout: got done=%0d want 1", fin);
      core_if.wen = 1'b0;
    end
    checks++;
    if (aw_cnt != aw_st + 1 || w_cnt != w_st + 1 || aw_extra != 0 || w_extra != 0) begin
      errors++; $display("FAIL store_valid_cycles: got aw=%0d w=%0d extra=%0d/%0d want %0d %0d 0/0",
                         aw_cnt, w_cnt, aw_extra, w_extra, aw_st + 1, w_st + 1);
    end
    checks++;
    if (got_addr !== (a & 32'hFFFF_FFFC) || got_cache !== (c ? 4'hF : 4'h0) ||
        got_fix !== {8'd0, 3'b010, 2'b01}) begin
      errors++; $display("FAIL store_aw_fields: got addr=%h cache=%h fix=%h want %h %h %h",
                         got_addr, got_cache, got_fix, a & 32'hFFFF_FFFC, c ? 4'hF : 4'h0,
                         {8'd0, 3'b010, 2'b01});
    end
    checks++;
    if (got_wdata !== wd || got_strb !== ws || got_last !== 1'b1) begin
      errors++; $display("FAIL store_w_fields: got data=%h strb=%b last=%b want %h %b 1",
                         got_wdata, got_strb, got_last, wd, ws);
    end
    checks++;
    if (early != 0 || bgap != 0) begin
      errors++; $display("FAIL store_bready: got early=%0d gaps=%0d want 0 0", early, bgap);
    end
    checks++;
    if (pulses != (killed ? 0 : 1) || rpulses != 0) begin
      errors++; $display("FAIL store_pulses: got b=%0d r=%0d want %0d 0", pulses, rpulses, killed ? 0 : 1);
    end
    if (!killed) begin
      checks++;
      if (pulse_n != exp_lat) begin
        errors++; $display("FAIL store_latency: got %0d want %0d", pulse_n, exp_lat);
      end
    end
    step();
    core_if.flush = 1'b0;
    checks++;
    if (axi_if.awvalid !== 1'b0 || core_if.rdata !== model_rdata) begin
      errors++; $display("FAIL store_after: got awvalid=%b rdata=%h want 0 %h",
                         axi_if.awvalid, core_if.rdata, model_rdata);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    checks++;
    if (any_out() !== 1'b0) begin
      errors++; $display("FAIL reset_outputs: got nonzero=%b want 0", any_out());
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_load_uncached();
    run_load(32'h1FC0_0006, 1'b0, 0, 1, -1, 1'b0);
  endtask

  task automatic test_store_cached();
    run_store(32'h8000_0010, 1'b1, 4'b0011, 32'h1234_5678, 3, 0, 0, -1);
  endtask

  task automatic test_flush_load();
    run_load(32'h2000_0040, 1'b1, 0, 2, 2, 1'b0);
    run_load(32'h0000_0100, 1'b0, 0, 0, -1, 1'b0);
  endtask

  task automatic test_r_backpressure();
    run_load(32'h0000_2228, 1'b0, 0, 10, -1, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_load(32'h0000_3000, 1'b1, 0, 0, -1, 1'b1);
    run_load(32'h0000_3004, 1'b0, 1, 0, -1, 1'b0);
  endtask

  task automatic test_reset_mid();
    bit hit;
    hit = 0;
    core_if.addr = 32'h4000_0000; core_if.wdata = 32'hCAFE_F00D; core_if.wsel = 4'hF;
    core_if.cached = 1'b1; core_if.ren = 1'b0; core_if.wen = 1'b1;
    for (int n = 0; n < 20 && !hit; n++) begin
      step();
      axi_if.awready = axi_if.awvalid;
      axi_if.wready  = axi_if.wvalid;
      axi_if.axi_bvalid = 1'b0;
      if (axi_if.bready) hit = 1;
    end
    checks++;
    if (!hit) begin
      errors++; $display("FAIL reset_mid_reach: got bready=%b want 1", hit);
    end
    rst = 1'b1; core_if.wen = 1'b0; axi_if.awready = 1'b0; axi_if.wready = 1'b0;
    step();
    checks++;
    if (any_out() !== 1'b0) begin
      errors++; $display("FAIL reset_mid_outputs: got nonzero=%b want 0", any_out());
    end
    rst = 1'b0;
    model_rdata = '0;
    step();
    run_store(32'h4000_0008, 1'b0, 4'b1100, 32'h0BAD_CAFE, 0, 1, 1, -1);
  endtask

  task automatic test_random();
    int s1, s2, s3, dur, fl;
    for (int i = 0; i < 16; i++) begin
      s1 = $urandom_range(3); s2 = $urandom_range(3); s3 = $urandom_range(3);
      if ($urandom_range(1) == 0) begin
        dur = 3 + s1 + s2;
        fl  = ($urandom_range(3) == 0) ? $urandom_range(dur, 1) : -1;
        run_load($urandom, 1'($urandom), s1, s2, fl, 1'b0);
      end else begin
        dur = 3 + ((s1 > s2) ? s1 : s2) + s3;
        fl  = ($urandom_range(3) == 0) ? $urandom_range(dur, 1) : -1;
        run_store($urandom, 1'($urandom), 4'($urandom), $urandom, s1, s2, s3, fl);
      end
    end
  endtask

  initial begin
    core_if.ren = 1'b0; core_if.wen = 1'b0; core_if.wsel = '0; core_if.addr = '0;
    core_if.wdata = '0; core_if.cached = 1'b0; core_if.flush = 1'b0;
    axi_if.arready = 1'b0; axi_if.rid = '0; axi_if.axi_rdata = '0; axi_if.rresp = '0;
    axi_if.rlast = 1'b0; axi_if.axi_rvalid = 1'b0; axi_if.awready = 1'b0;
    axi_if.wready = 1'b0; axi_if.bid = '0; axi_if.bresp = '0; axi_if.axi_bvalid = 1'b0;
    test_reset();
    test_load_uncached();
    test_store_cached();
    test_flush_load();
    test_r_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ls_axi_bridge.md
# ls_axi_bridge

Responder for the core's load/store data port: accepts the single-word load and store requests the core drives and executes each one as a single-beat AXI4 master transaction. Returns a one-cycle `rvalid` or `bvalid` completion pulse to the core. Honours the core's flush by completing the in-flight AXI transaction and suppressing its completion. Sits between the core's data port and the AXI crossbar, beside the instruction fetch path.

## Interface
- `ID_W`, default 4: AXI ID width; all IDs are driven 0.
- `clock`  in  1  sole clock.
- `reset`  in  1  synchronous, active-high.
- `ren` / `wen`  in  1 / 1  load / store request; held by the core until its completion pulse.
- `wsel`  in  4  store byte lanes.
- `addr`  in  32  physical address.
- `wdata`  in  32  store data.
- `cached`  in  1  1 = cacheable transfer.
- `flush`  in  1  kill the current request.
- `rdata`  out  32  load data.
- `rvalid` / `bvalid`  out  1 / 1  load / store completion pulse.
- AXI AR: `arid`, `araddr[31:0]`, `arlen[7:0]`, `arsize[2:0]`, `arburst[1:0]`, `arcache[3:0]`, `arvalid` out; `arready` in.
- AXI R: `rid`, `axi_rdata[31:0]`, `rresp[1:0]`, `rlast`, `axi_rvalid` in; `rready` out.
- AXI AW: same field set as AR plus `awvalid` out; `awready` in.
- AXI W: `axi_wdata[31:0]`, `wstrb[3:0]`, `wlast`, `wvalid` out; `wready` in.
- AXI B: `bid`, `bresp[1:0]`, `axi_bvalid` in; `bready` out.

## Operation
- States: IDLE, RD_ADDR, RD_DATA, WR, WR_RESP, DONE.
- IDLE:
  - With `flush` = 0, `wen` takes priority over `ren`. The request latches `addr`, `wdata`, `wsel`, `cached` and `is_write`, clears `killed`, and moves to WR (store) or RD_ADDR (load).
  - With `flush` = 1, requests are ignored that cycle.
- RD_ADDR: `arvalid` = 1 until `arready` -> RD_DATA.
- RD_DATA: `rready` = 1. On `axi_rvalid` with `rlast`: latch `axi_rdata` into `rdata` -> DONE.
- WR:
  - `awvalid` and `wvalid` assert together. Each drops independently on its own handshake, tracked by sticky `aw_done` / `w_done`.
  - Both done -> WR_RESP. A same-cycle double handshake qualifies.
- WR_RESP: `bready` = 1. On `axi_bvalid` -> DONE.
- DONE, one cycle:
  - `rvalid` = !is_write && !killed && !flush.
  - `bvalid` = is_write && !killed && !flush.
  - Then -> IDLE. Requests are never sampled in DONE, so the still-held request is not reissued.
- Flush:
  - `flush` in any non-IDLE state sets `killed`.
  - The AXI transaction still completes fully, because AXI has no abort.
- Field encodings:
  - `ar/awaddr` = {addr[31:2], 2'b00}.
  - `arlen` = 0, `arsize` = 3'b010, `arburst` = 2'b01.
  - `ar/awcache` = `cached` ? 4'b1111 : 4'b0000.
  - `wstrb` = `wsel`, `wlast` = 1.
- `rresp`, `bresp`, `rid`, `bid` are ignored; error responses still complete normally.
- `rdata` holds its value until the next load completes.

## Timing
- Reset: state IDLE; every output 0, including `rdata`; `killed`, `aw_done`, `w_done` cleared.
- Reset mid-transaction aborts immediately with all AXI valids low the next cycle. Reset is system-wide, so the interconnect is reset too.
- AXI valids are registered. They never depend combinationally on ready inputs.
- Minimum latency, request sampled at cycle T:
  - `arvalid` / `awvalid` at T+1.
  - `axi_rvalid` / `axi_bvalid` accepted at T+2.
  - Core pulse at T+3.
- Each stall cycle on any AXI channel adds exactly one cycle.
- One outstanding transaction at a time.
- After a pulse at cycle D, a request present at D+1 is sampled at D+1.

## Structure
- Package `ls_axi_pkg`:
  - state enum;
  - `AXI_SIZE_WORD`, `AXI_BURST_INCR`, `AXI_CACHE_WBRA` (4'b1111), `AXI_CACHE_DEV` (4'b0000).
- No sub-module. Single FSM plus request registers, about 200 lines.

## Test plan
- Load, uncached: `addr` 0x1FC0_0006, `arready` immediate, R returns 0xDEADBEEF two cycles later -> `araddr` 0x1FC0_0004, `arcache` 0, a single `rvalid` pulse with `rdata` 0xDEADBEEF at the T+4 point.
- Store, cached: `addr` 0x8000_0010, `wsel` 4'b0011, `wdata` 0x12345678, `wready` immediate, `awready` after 3 cycles:
  - `wvalid` high for 1 cycle only; `awvalid` held 4 cycles;
  - `wstrb` 0011, `awcache` 1111;
  - exactly one `bvalid` pulse after B.
- Flush in RD_DATA -> R still accepted, no `rvalid`. A following `ren` to 0x100 issues a new AR and completes normally.
- R backpressure of 10 cycles -> `arvalid` low after its handshake, `rready` high throughout, no core pulse until `axi_rvalid`.
- `ren` held through DONE -> exactly one AR per request; a second held request starts only at D+1.
- Reset asserted in WR_RESP -> next cycle all outputs 0 and state IDLE. A subsequent store completes normally.
